// File: rtl/vga_scan_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | vga_scan_ctrl : 640x480@60 VGA scan generator with pixel-clock enable,   |
// |   shared row/col bus, and a two-tick registered pixel/sync path.         |
// |   Optional colour-bar generator: define VGA_TEST_PATTERN_EN.             |
// | Revision: 1.0 - initial release                                          |
// +------------------------------------------------------------------------+
module vga_scan_ctrl #(
  parameter int CLK_DIV  = 4,
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] d_in,
  input  logic        test_mode,
  output logic [8:0]  row,
  output logic [9:0]  col,
  output logic        rdn,
  output logic        pix_tick,
  output logic        frame_start,
  output logic        hs,
  output logic        vs,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int HW = ($clog2(H_TOTAL) > 10) ? $clog2(H_TOTAL) : 10;
  localparam int VW = ($clog2(V_TOTAL) > 10) ? $clog2(V_TOTAL) : 10;

  localparam logic [DW-1:0] C_DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] C_H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] C_H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] C_H_SYNC_S = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] C_H_SYNC_E = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] C_V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] C_V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] C_V_SYNC_S = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] C_V_SYNC_E = VW'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          tick_d;
  logic          active_q, active_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic [11:0]   pixel_d;

`ifdef VGA_TEST_PATTERN_EN
  logic [11:0]   bar_rgb_d;

  // Eight 80-pixel bars keyed off the column already presented on the bus.
  always_comb begin
    if      (col < 10'd80)  bar_rgb_d = 12'hfff;
    else if (col < 10'd160) bar_rgb_d = 12'hff0;
    else if (col < 10'd240) bar_rgb_d = 12'h0ff;
    else if (col < 10'd320) bar_rgb_d = 12'h0f0;
    else if (col < 10'd400) bar_rgb_d = 12'hf0f;
    else if (col < 10'd480) bar_rgb_d = 12'hf00;
    else if (col < 10'd560) bar_rgb_d = 12'h00f;
    else                    bar_rgb_d = 12'h000;
  end
`else
  logic          w_unused_test_mode;
  assign w_unused_test_mode = test_mode;
`endif

  always_comb begin
    tick_d = (div_q == C_DIV_LAST);
    div_d  = tick_d ? '0 : div_q + 1'b1;
    h_d    = h_q;
    v_d    = v_q;
    if (tick_d) begin
      if (h_q == C_H_LAST) begin
        h_d = '0;
        v_d = (v_q == C_V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
    active_d = (h_q < C_H_ACT) && (v_q < C_V_ACT);
    hsync_d  = (h_q >= C_H_SYNC_S) && (h_q < C_H_SYNC_E);
    vsync_d  = (v_q >= C_V_SYNC_S) && (v_q < C_V_SYNC_E);
`ifdef VGA_TEST_PATTERN_EN
    pixel_d  = active_q ? (test_mode ? bar_rgb_d : d_in) : 12'h000;
`else
    pixel_d  = active_q ? d_in : 12'h000;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q       <= '0;
      h_q         <= '0;
      v_q         <= '0;
      pix_tick    <= 1'b0;
      frame_start <= 1'b0;
      row         <= '0;
      col         <= '0;
      rdn         <= 1'b1;
      active_q    <= 1'b0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      {r, g, b}   <= 12'h000;
    end else begin
      div_q       <= div_d;
      h_q         <= h_d;
      v_q         <= v_d;
      pix_tick    <= tick_d;
      frame_start <= tick_d && (h_q == '0) && (v_q == '0);
      if (tick_d) begin
        // Stage 0 presents the current coordinate; stage 1 emits the previous one.
        row       <= active_d ? v_q[8:0] : '0;
        col       <= active_d ? h_q[9:0] : '0;
        rdn       <= ~active_d;
        active_q  <= active_d;
        hsync_q   <= hsync_d;
        vsync_q   <= vsync_d;
        hs        <= ~hsync_q;
        vs        <= ~vsync_q;
        {r, g, b} <= pixel_d;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_ctrl.sv
`default_nettype none
// Bench for vga_scan_ctrl: a reduced-geometry instance checked every clock
// against a raster-position model, plus a full 640x480 instance for line timing.
module tb_vga_scan_ctrl;

  localparam int D  = 2;
  localparam int HA = 170, HF = 6, HS = 10, HT = 200;
  localparam int VA = 6,   VF = 2, VS = 2,  VT = 12;
`ifdef VGA_TEST_PATTERN_EN
  localparam bit PAT = 1'b1;
`else
  localparam bit PAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst_full, test_mode;
  logic [11:0] d_in;
  logic [8:0]  row;
  logic [9:0]  col;
  logic        rdn, pix_tick, frame_start, hs, vs;
  logic [3:0]  r, g, b;

  logic [8:0]  f_row;
  logic [9:0]  f_col;
  logic        f_rdn, f_pix_tick, f_frame_start, f_hs, f_vs;
  logic [3:0]  f_r, f_g, f_b;

  vga_scan_ctrl #(
    .CLK_DIV(D), .H_TOTAL(HT), .V_TOTAL(VT),
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS)
  ) u_dut (
    .clk(clk), .rst(rst), .d_in(d_in), .test_mode(test_mode),
    .row(row), .col(col), .rdn(rdn), .pix_tick(pix_tick),
    .frame_start(frame_start), .hs(hs), .vs(vs), .r(r), .g(g), .b(b)
  );

  vga_scan_ctrl u_full (
    .clk(clk), .rst(rst_full), .d_in(d_in), .test_mode(1'b0),
    .row(f_row), .col(f_col), .rdn(f_rdn), .pix_tick(f_pix_tick),
    .frame_start(f_frame_start), .hs(f_hs), .vs(f_vs), .r(f_r), .g(f_g), .b(f_b)
  );

  int tests = 0;
  int fails = 0;
  int n = 0;
  int fs_count = 0;
  logic [11:0] din_tick = 12'h000;
  logic        tm_tick  = 1'b0;

  // Full-size instance: record clock index of every hs edge after release.
  int unsigned full_n = 0;
  logic        f_hs_prev = 1'b1;
  int unsigned hs_falls[$];
  int unsigned hs_rises[$];

  always @(posedge clk) full_n <= rst_full ? 0 : full_n + 1;

  always @(negedge clk) begin
    if (f_hs_prev && !f_hs) hs_falls.push_back(full_n);
    if (!f_hs_prev && f_hs) hs_rises.push_back(full_n);
    f_hs_prev <= f_hs;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] bar_colour(input int c);
    case (c / 80)
      0: return 12'hfff;
      1: return 12'hff0;
      2: return 12'h0ff;
      3: return 12'h0f0;
      4: return 12'hf0f;
      5: return 12'hf00;
      6: return 12'h00f;
      default: return 12'h000;
    endcase
  endfunction

  // After n unreset edges, k = n/D ticks have occurred; tick k presents raster
  // position k-1 on row/col and drives the pins for position k-2.
  task automatic check_outputs();
    int k, p, h0, v0, h1, v1;
    bit a0, a1, pt, hs_e, vs_e;
    logic [11:0] rgb_e;
    k  = n / D;
    pt = (n > 0) && (n % D == 0);
    a0 = 1'b0; h0 = 0; v0 = 0;
    if (k >= 1) begin
      p  = k - 1;
      h0 = p % HT;
      v0 = (p / HT) % VT;
      a0 = (h0 < HA) && (v0 < VA);
    end
    hs_e = 1'b1; vs_e = 1'b1; rgb_e = 12'h000;
    if (k >= 2) begin
      p  = k - 2;
      h1 = p % HT;
      v1 = (p / HT) % VT;
      a1 = (h1 < HA) && (v1 < VA);
      hs_e = !((h1 >= HA + HF) && (h1 < HA + HF + HS));
      vs_e = !((v1 >= VA + VF) && (v1 < VA + VF + VS));
      if (a1) rgb_e = (PAT && tm_tick) ? bar_colour(h1) : din_tick;
    end
    check("row",         32'(row),         a0 ? 32'(v0) : 32'd0);
    check("col",         32'(col),         a0 ? 32'(h0) : 32'd0);
    check("rdn",         32'(rdn),         32'(!a0));
    check("pix_tick",    32'(pix_tick),    32'(pt));
    check("frame_start", 32'(frame_start), 32'(pt && k >= 1 && h0 == 0 && v0 == 0));
    check("hs",          32'(hs),          32'(hs_e));
    check("vs",          32'(vs),          32'(vs_e));
    check("rgb",         32'({r, g, b}),   32'(rgb_e));
    if (frame_start === 1'b1) fs_count++;
  endtask

  // One clock: drive at the falling edge, model the rising edge, check at the next fall.
  task automatic cycle(input logic rst_v);
    rst       = rst_v;
    d_in      = ($urandom_range(0, 1) == 1) ? 12'($urandom) : {row[3:0], col[3:0], col[7:4]};
    test_mode = ($urandom_range(0, 3) == 0);
    @(posedge clk);
    if (rst) n = 0;
    else     n++;
    if (!rst && (n % D == 0)) begin
      din_tick = d_in;
      tm_tick  = test_mode;
    end
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    rst = 1'b1; rst_full = 1'b1; d_in = 12'h000; test_mode = 1'b0;
    @(negedge clk);
    repeat (3) cycle(1'b1);
    rst_full = 1'b0;
    repeat (300) cycle(1'b0);
    // Abandon the frame mid-line and restart from (0,0).
    repeat (3) cycle(1'b1);
    fs_count = 0;
    repeat (3 * HT * VT * D) cycle(1'b0);
    check("frame_start_per_frame", 32'(fs_count), 32'd3);

    check("full_hs_edges_seen", 32'(hs_falls.size() >= 2 && hs_rises.size() >= 1), 32'd1);
    if (hs_falls.size() >= 2 && hs_rises.size() >= 1) begin
      check("full_first_hs_fall", hs_falls[0], 32'd2632);
      check("full_hs_period",     hs_falls[1] - hs_falls[0], 32'd3200);
      check("full_hs_low_width",  hs_rises[0] - hs_falls[0], 32'd384);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
